// File: rtl/shift_add_mac.sv
// -----------------------------------------------------------------------------
// shift_add_mac
//
// Sequential unsigned shift-add multiplier with an addend:
//   PRODUCT = MULTIPLICAND * MULTIPLIER + ADDEND
// The result takes exactly WIDTH iterations, one per clock, after the
// acceptance edge. The addend is preloaded into the upper accumulator. After
// WIDTH right shifts it therefore lands unscaled in the product. This is
// what lets divisor*quotient+remainder rebuild a dividend.
//
// Ports
//   CLK           in   1        clock, rising edge
//   RST           in   1        asynchronous reset, active low
//   START         in   1        request, honoured in IDLE or DONE only
//   MULTIPLICAND  in   WIDTH    operand M, latched on acceptance
//   MULTIPLIER    in   WIDTH    operand Q, latched on acceptance
//   ADDEND        in   WIDTH    operand R, latched on acceptance
//   READY         out  1        result valid (level), falls on acceptance
//   PRODUCT       out  2*WIDTH  M*Q+R, held until the next result is written
// -----------------------------------------------------------------------------
module shift_add_mac #(
  parameter int WIDTH = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic [WIDTH-1:0]   MULTIPLICAND,
  input  logic [WIDTH-1:0]   MULTIPLIER,
  input  logic [WIDTH-1:0]   ADDEND,
  output logic               READY,
  output logic [2*WIDTH-1:0] PRODUCT
);

  // The counter holds 0..WIDTH-1. One spare bit keeps it 5 bits wide for WIDTH=16.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // no result since reset
    S_CALC = 2'd1,  // iterating
    S_DONE = 2'd2   // result valid
  } state_e;

  state_e               state_q,   state_d;
  logic                 c_q,       c_d;
  logic [WIDTH-1:0]     a_q,       a_d;
  logic [WIDTH-1:0]     qr_q,      qr_d;
  logic [WIDTH-1:0]     mr_q,      mr_d;
  logic [CW-1:0]        count_q,   count_d;
  logic                 ready_q,   ready_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic                 accept;
  logic                 last_iter;
  logic [WIDTH:0]       sum;        // {carry, A} after the conditional add
  logic [WIDTH-1:0]     a_shift;
  logic [WIDTH-1:0]     qr_shift;

  // A request is only taken when no operation is in flight. START during CALC
  // is dropped, not queued.
  assign accept    = START && (state_q != S_CALC);
  assign last_iter = (count_q == LAST_COUNT);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: every flop, datapath included, is cleared by the asynchronous reset.
  // As a result, an abort mid-CALC leaves no stale partial result behind and
  // needs no extra sequencing.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      c_q       <= 1'b0;
      a_q       <= '0;
      qr_q      <= '0;
      mr_q      <= '0;
      count_q   <= '0;
      ready_q   <= 1'b0;
      product_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let every register sample the
      // pre-edge values of the others. This models real flops regardless of
      // statement order.
      state_q   <= state_d;
      c_q       <= c_d;
      a_q       <= a_d;
      qr_q      <= qr_d;
      mr_q      <= mr_d;
      count_q   <= count_d;
      ready_q   <= ready_d;
      product_q <= product_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: the default assignment first means every path assigns state_d,
    // so no latch can be inferred.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept)    state_d = S_CALC;
      S_CALC:  if (last_iter) state_d = S_DONE;
      S_DONE:  if (accept)    state_d = S_CALC;
      default:                state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // One shift-add step
  // ---------------------------------------------------------------------------
  // C is zero between iterations because a zero is shifted into it. It is
  // still kept as the top bit of the adder input, so the 17-bit sum holds its
  // carry. That carry is then shifted down into A's MSB. Dropping it would
  // corrupt any step where A + Mr overflows WIDTH bits.
  always_comb begin
    sum      = {c_q, a_q} + {1'b0, (qr_q[0] ? mr_q : {WIDTH{1'b0}})};
    a_shift  = sum[WIDTH:1];
    qr_shift = {sum[0], qr_q[WIDTH-1:1]};
  end

  // ---------------------------------------------------------------------------
  // Datapath and output next values
  // ---------------------------------------------------------------------------
  always_comb begin
    c_d       = c_q;
    a_d       = a_q;
    qr_d      = qr_q;
    mr_d      = mr_q;
    count_d   = count_q;
    ready_d   = ready_q;
    product_d = product_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          // The addend seeds the upper half. WIDTH right shifts later it
          // sits unscaled in the result.
          mr_d    = MULTIPLICAND;
          qr_d    = MULTIPLIER;
          a_d     = ADDEND;
          c_d     = 1'b0;
          count_d = '0;
          // PRODUCT keeps the previous result until the new one is written.
          ready_d = 1'b0;
        end
      end

      S_CALC: begin
        c_d     = 1'b0;
        a_d     = a_shift;
        qr_d    = qr_shift;
        count_d = count_q + 1'b1;
        if (last_iter) begin
          product_d = {a_shift, qr_shift};
          ready_d   = 1'b1;
        end
      end

      default: ;
    endcase
  end

  assign READY   = ready_q;
  assign PRODUCT = product_q;

endmodule

// File: tb/tb_shift_add_mac.sv
// -----------------------------------------------------------------------------
// tb_shift_add_mac
//
// Self-checking bench for shift_add_mac. The expected product comes from
// plain arithmetic, M*Q+R, or from the dividend when driven as a divider
// check. It is never derived from the shift-add algorithm itself. Inputs are
// driven on the falling edge or 1 ns after the rising edge. Outputs are
// sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_shift_add_mac;

  localparam int WIDTH = 16;

  logic               CLK = 1'b0;
  logic               RST;
  logic               START;
  logic [WIDTH-1:0]   MULTIPLICAND;
  logic [WIDTH-1:0]   MULTIPLIER;
  logic [WIDTH-1:0]   ADDEND;
  logic               READY;
  logic [2*WIDTH-1:0] PRODUCT;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_prod = '0;   // result the DUT should currently be holding

  shift_add_mac #(.WIDTH(WIDTH)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .START        (START),
    .MULTIPLICAND (MULTIPLICAND),
    .MULTIPLIER   (MULTIPLIER),
    .ADDEND       (ADDEND),
    .READY        (READY),
    .PRODUCT      (PRODUCT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [15:0] m, input logic [15:0] q,
                                        input logic [15:0] r);
    return 32'(m) * 32'(q) + 32'(r);
  endfunction

  // Present operands and START and let one rising edge accept them. Then
  // drop START, scramble the inputs, and confirm READY fell while the old
  // PRODUCT stayed.
  task automatic accept_op(input logic [15:0] m, input logic [15:0] q,
                           input logic [15:0] r, input string tag);
    @(negedge CLK);
    MULTIPLICAND = m;
    MULTIPLIER   = q;
    ADDEND       = r;
    START        = 1'b1;
    @(posedge CLK);
    #1;
    START        = 1'b0;
    MULTIPLICAND = 16'($urandom);
    MULTIPLIER   = 16'($urandom);
    ADDEND       = 16'($urandom);
    check({tag, ".ready_low"}, 32'(READY), 32'd0);
    check({tag, ".prod_hold"}, PRODUCT, exp_prod);
  endtask

  // Count edges after acceptance until READY rises. The wait is bounded.
  // START is pulsed so it is sampled on edges p1 and p2 (0 = no pulse), with
  // random operands that must be ignored.
  task automatic wait_done(input logic [31:0] expected, input string tag,
                           input int p1, input int p2);
    int lat;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge CLK);
      #1;
      if (READY === 1'b1) begin
        lat = i;
        break;
      end
      START = ((i == p1 - 1) || (i == p2 - 1));
      if (START) begin
        MULTIPLICAND = 16'($urandom);
        MULTIPLIER   = 16'($urandom);
        ADDEND       = 16'($urandom);
      end
    end
    START = 1'b0;
    check({tag, ".latency"}, 32'(lat), 32'd16);
    check({tag, ".product"}, PRODUCT, expected);
    exp_prod = expected;
  endtask

  task automatic run_op(input logic [15:0] m, input logic [15:0] q,
                        input logic [15:0] r, input string tag);
    accept_op(m, q, r, tag);
    wait_done(model(m, q, r), tag, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit exceeded");
  end

  initial begin
    logic [15:0] dividend, divisor, quo, rem;
    logic [31:0] e1, e2;

    // Reset with START held high: reset must win.
    RST          = 1'b0;
    START        = 1'b1;
    MULTIPLICAND = 16'd7;
    MULTIPLIER   = 16'd7;
    ADDEND       = 16'd7;
    repeat (3) @(posedge CLK);
    #1;
    check("reset.ready", 32'(READY), 32'd0);
    check("reset.product", PRODUCT, 32'd0);
    @(negedge CLK);
    START = 1'b0;
    RST   = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("idle.ready", 32'(READY), 32'd0);

    // First operation, then verify the result holds while START stays low.
    run_op(16'd4, 16'd2, 16'd1, "basic");
    check("basic.value", exp_prod, 32'd9);
    repeat (5) @(posedge CLK);
    #1;
    check("hold.ready", 32'(READY), 32'd1);
    check("hold.product", PRODUCT, 32'd9);

    // Three sequential operations with fixed expected values.
    accept_op(16'd3, 16'd6, 16'd2, "seq0");
    wait_done(32'd20, "seq0", 0, 0);
    accept_op(16'd7, 16'd14, 16'd2, "seq1");
    wait_done(32'd100, "seq1", 0, 0);
    accept_op(16'd0, 16'd1234, 16'd55, "seq2");
    wait_done(32'd55, "seq2", 0, 0);

    // Carry stress.
    accept_op(16'hFFFF, 16'hFFFF, 16'hFFFF, "carry0");
    wait_done(32'hFFFF_0000, "carry0", 0, 0);
    accept_op(16'hFFFF, 16'h8001, 16'h0000, "carry1");
    wait_done(32'h8000_7FFF, "carry1", 0, 0);

    // START pulses on edges 3 and 10 during CALC must be ignored.
    accept_op(16'h1234, 16'h00FF, 16'h0042, "ignore");
    wait_done(model(16'h1234, 16'h00FF, 16'h0042), "ignore", 3, 10);

    // Back-to-back: START held high. It is not accepted on the edge where
    // READY rises, but it is accepted on the next edge.
    e1 = model(16'd100, 16'd200, 16'd300);
    e2 = model(16'hABCD, 16'h1357, 16'h2468);
    accept_op(16'd100, 16'd200, 16'd300, "b2b0");
    MULTIPLICAND = 16'hABCD;
    MULTIPLIER   = 16'h1357;
    ADDEND       = 16'h2468;
    START        = 1'b1;
    repeat (16) @(posedge CLK);
    #1;
    check("b2b.edge16_ready", 32'(READY), 32'd1);
    check("b2b.edge16_product", PRODUCT, e1);
    @(posedge CLK);
    #1;
    START = 1'b0;
    check("b2b.edge17_ready", 32'(READY), 32'd0);
    check("b2b.edge17_product", PRODUCT, e1);
    wait_done(e2, "b2b1", 0, 0);

    // Asynchronous reset in the middle of CALC.
    accept_op(16'h0F0F, 16'h3333, 16'h0001, "abort");
    repeat (8) @(posedge CLK);
    #3;
    RST = 1'b0;
    #1;
    check("abort.ready", 32'(READY), 32'd0);
    check("abort.product", PRODUCT, 32'd0);
    exp_prod = '0;
    @(negedge CLK);
    RST = 1'b1;
    run_op(16'd5, 16'd5, 16'd0, "after_abort");

    // Divider loop: divisor*quotient+remainder must rebuild the dividend.
    for (int k = 0; k < 200; k++) begin
      dividend = 16'($urandom);
      divisor  = 16'($urandom_range(1, 65535));
      if (k % 4 == 0) divisor = 16'($urandom_range(1, 15));
      quo = dividend / divisor;
      rem = dividend % divisor;
      accept_op(divisor, quo, rem, "div");
      wait_done({16'd0, dividend}, "div", 0, 0);
    end

    // General random operands.
    for (int k = 0; k < 40; k++) begin
      run_op(16'($urandom), 16'($urandom), 16'($urandom), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
